// File: rtl/logic4_pkg.sv
// Shared definitions for the logic4 arbitrated scheduler: FSM encoding,
// requester-index width and the round-robin pointer advance.
package logic4_pkg;

  localparam int IDW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx, input int nreq);
    return (int'(idx) == nreq - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/logic4_core.sv
// Shared 4-bit combinational logic core; one instance is time-multiplexed among requesters.
module logic4_core (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);

  assign y[0] = a[0] & b[0] & a[1] & b[1];
  assign y[1] = a[2] & (a[1] | b[1]) & b[0] & ~b[3];
  assign y[2] = (a[3] & b[3]) ^ a[2];
  assign y[3] = a[3] | b[3] | b[2];

endmodule

// File: rtl/logic4_arb_sched.sv
// Round-robin arbiter feeding a single logic4_core: accept one operand pair,
// compute for one cycle, then hold the result until the consumer takes it.
module logic4_arb_sched
  import logic4_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int CNTW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0]        rsp_y,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy,
  output logic [CNTW-1:0]   op_count
);

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_vld;
  logic [3:0]     sel_a;
  logic [3:0]     sel_b;
  logic [3:0]     op_a_p0;
  logic [3:0]     op_b_p0;
  logic [IDW-1:0] op_id_p0;
  logic [3:0]     core_y;

  // Scan downwards so the requester closest to rr_ptr is the last to overwrite.
  always_comb begin : grant_sel
    int              j;
    logic [NREQ-1:0] vshift;
    j       = 0;
    vshift  = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (rst_n && state == IDLE) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        j = int'(rr_ptr) + k;
        if (j >= NREQ) j = j - NREQ;
        vshift = req_valid >> j;
        if (vshift[0]) begin
          gnt_vld = 1'b1;
          gnt_idx = IDW'(j);
        end
      end
    end
  end

  assign req_ready = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
  assign sel_a     = 4'(req_a >> {gnt_idx, 2'b00});
  assign sel_b     = 4'(req_b >> {gnt_idx, 2'b00});
  assign busy      = (state != IDLE);

  logic4_core u_core (
    .a (op_a_p0),
    .b (op_b_p0),
    .y (core_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_a_p0   <= '0;
      op_b_p0   <= '0;
      op_id_p0  <= '0;
      rsp_y     <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        // Stage p0: capture the granted operands.
        IDLE: begin
          if (gnt_vld) begin
            op_a_p0  <= sel_a;
            op_b_p0  <= sel_b;
            op_id_p0 <= gnt_idx;
            rr_ptr   <= wrap_inc(gnt_idx, NREQ);
            state    <= EXEC;
          end
        end
        // Stage p1: register the core result as the response.
        EXEC: begin
          rsp_y     <= core_y;
          rsp_id    <= op_id_p0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            if (op_count != '1) op_count <= op_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic4_arb_sched.sv
// Bench for logic4_arb_sched: two instances (2 requesters / 8-bit count and
// 4 requesters / 2-bit count) checked against a transaction-level model.
module tb_logic4_arb_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0]  a_valid, a_ready;
  logic [7:0]  a_a, a_b;
  logic        a_rsp_valid, a_rsp_ready;
  logic [3:0]  a_y;
  logic [1:0]  a_id;
  logic        a_busy;
  logic [7:0]  a_cnt;

  logic [3:0]  b_valid, b_ready;
  logic [15:0] b_a, b_b;
  logic        b_rsp_valid, b_rsp_ready;
  logic [3:0]  b_y;
  logic [1:0]  b_id;
  logic        b_busy;
  logic [1:0]  b_cnt;

  int n_chk = 0;
  int n_fail = 0;

  logic4_arb_sched #(.NREQ(2), .CNTW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
    .req_a(a_a), .req_b(a_b), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_y(a_y), .rsp_id(a_id), .busy(a_busy), .op_count(a_cnt)
  );

  logic4_arb_sched #(.NREQ(4), .CNTW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_a(b_a), .req_b(b_b), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_y(b_y), .rsp_id(b_id), .busy(b_busy), .op_count(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] core_ref(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] y;
    y[0] = a[0] & b[0] & a[1] & b[1];
    y[1] = a[2] & (a[1] | b[1]) & b[0] & ~b[3];
    y[2] = (a[3] & b[3]) ^ a[2];
    y[3] = a[3] | b[3] | b[2];
    return y;
  endfunction

  // Transaction-level model: an operation is either computing, waiting for
  // its consumer, or absent; grants go to the first valid from the pointer.
  typedef struct {
    bit         computing;
    bit         pending;
    int         ptr;
    int         id;
    logic [3:0] y;
    int         cnt;
  } mdl_t;
  mdl_t m [2];

  task automatic mon(input int k, input int n, input int cmax,
                     input logic [3:0] rv, input logic [15:0] ra, input logic [15:0] rb,
                     input logic rr, input logic [3:0] o_ready, input logic o_vld,
                     input logic [3:0] o_y, input logic [1:0] o_id, input logic o_busy,
                     input int o_cnt);
    string      pfx;
    int         g;
    bit         idle;
    logic [3:0] exp_rdy;
    pfx = (k == 0) ? "A." : "B.";
    if (!rst_n) begin
      m[k].computing = 0; m[k].pending = 0; m[k].ptr = 0;
      m[k].id = 0; m[k].y = '0; m[k].cnt = 0;
      chk({pfx, "rst_ready"}, o_ready, 0);
      chk({pfx, "rst_vld"}, o_vld, 0);
      chk({pfx, "rst_y"}, o_y, 0);
      chk({pfx, "rst_id"}, o_id, 0);
      chk({pfx, "rst_busy"}, o_busy, 0);
      chk({pfx, "rst_cnt"}, o_cnt, 0);
      return;
    end
    idle = !m[k].computing && !m[k].pending;
    g = -1;
    exp_rdy = '0;
    if (idle) begin
      for (int j = 0; j < n; j++) begin
        int i;
        i = (m[k].ptr + j) % n;
        if (g < 0 && rv[i]) g = i;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk({pfx, "ready"}, o_ready, exp_rdy);
    chk({pfx, "busy"}, o_busy, !idle);
    chk({pfx, "rsp_valid"}, o_vld, m[k].pending);
    if (m[k].pending) begin
      chk({pfx, "rsp_y"}, o_y, m[k].y);
      chk({pfx, "rsp_id"}, o_id, m[k].id);
    end
    chk({pfx, "op_count"}, o_cnt, m[k].cnt);
    if (g >= 0) begin
      m[k].computing = 1;
      m[k].id = g;
      m[k].y = core_ref(ra[4*g +: 4], rb[4*g +: 4]);
      m[k].ptr = (g + 1) % n;
    end else if (m[k].computing) begin
      m[k].computing = 0;
      m[k].pending = 1;
    end else if (m[k].pending && rr) begin
      m[k].pending = 0;
      if (m[k].cnt < cmax) m[k].cnt++;
    end
  endtask

  always @(negedge clk) begin
    mon(0, 2, 255, {2'b00, a_valid}, {8'h00, a_a}, {8'h00, a_b}, a_rsp_ready,
        {2'b00, a_ready}, a_rsp_valid, a_y, a_id, a_busy, int'(a_cnt));
    mon(1, 4, 3, b_valid, b_a, b_b, b_rsp_ready,
        b_ready, b_rsp_valid, b_y, b_id, b_busy, int'(b_cnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int got_id[$];
  int got_y[$];
  int grants[$];
  int hs_done;
  bit seen;

  initial begin
    rst_n = 1'b0;
    a_valid = '0; a_a = '0; a_b = '0; a_rsp_ready = 1'b0;
    b_valid = '0; b_a = '0; b_b = '0; b_rsp_ready = 1'b0;
    tick(); tick();
    chk("reset_cnt", a_cnt, 0);
    chk("reset_vld", a_rsp_valid, 0);
    rst_n = 1'b1;
    tick();

    // Single request from requester 0.
    a_valid = 2'b01; a_a = 8'hFF; a_b = 8'hFF; a_rsp_ready = 1'b1;
    #1 chk("single_ready", a_ready, 2'b01);
    tick();
    a_valid = 2'b00;
    chk("single_vld_t0", a_rsp_valid, 0);
    chk("single_busy", a_busy, 1);
    tick();
    chk("single_vld_t1", a_rsp_valid, 1);
    chk("single_y", a_y, 4'h9);
    chk("single_id", a_id, 0);
    tick();
    chk("single_cnt", a_cnt, 1);
    chk("single_vld_done", a_rsp_valid, 0);

    // Backpressure while holding a response for requester 1.
    a_rsp_ready = 1'b0;
    a_valid = 2'b10; a_a = 8'h80; a_b = 8'h00;
    tick();
    a_valid = 2'b11;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_vld", a_rsp_valid, 1);
      chk("bp_y", a_y, 4'h8);
      chk("bp_id", a_id, 1);
      chk("bp_ready", a_ready, 0);
      chk("bp_busy", a_busy, 1);
      chk("bp_cnt", a_cnt, 1);
      tick();
    end
    a_valid = 2'b00;
    a_rsp_ready = 1'b1;
    tick();
    chk("bp_cnt_after", a_cnt, 2);

    // Two requesters held valid through reset.
    rst_n = 1'b0;
    a_valid = 2'b11; a_a = 8'h87; a_b = 8'h03;
    #1 chk("rst_ready_low", a_ready, 0);
    chk("rst_cnt_clear", a_cnt, 0);
    tick();
    rst_n = 1'b1;
    got_id.delete(); got_y.delete();
    for (int c = 0; c < 30 && got_id.size() < 3; c++) begin
      @(negedge clk);
      if (a_rsp_valid && a_rsp_ready) begin
        got_id.push_back(int'(a_id));
        got_y.push_back(int'(a_y));
      end
    end
    tick();
    a_valid = 2'b00;
    chk("simul_count", got_id.size(), 3);
    if (got_id.size() == 3) begin
      chk("simul_id0", got_id[0], 0); chk("simul_y0", got_y[0], 7);
      chk("simul_id1", got_id[1], 1); chk("simul_y1", got_y[1], 8);
      chk("simul_id2", got_id[2], 0); chk("simul_y2", got_y[2], 7);
    end
    tick(); tick(); tick();

    // Reset while computing.
    a_valid = 2'b01; a_a = 8'hFF; a_b = 8'hFF;
    tick();
    a_valid = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vld", a_rsp_valid, 0);
    chk("midrst_y", a_y, 0);
    chk("midrst_id", a_id, 0);
    chk("midrst_busy", a_busy, 0);
    chk("midrst_cnt", a_cnt, 0);
    chk("midrst_ready", a_ready, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("midrst_no_stale", a_rsp_valid, 0);
    end
    a_valid = 2'b10; a_a = 8'h80; a_b = 8'h00;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (a_rsp_valid) begin
        seen = 1;
        chk("midrst_next_id", a_id, 1);
        chk("midrst_next_y", a_y, 4'h8);
      end
    end
    chk("midrst_next_seen", seen, 1);
    tick();
    a_valid = 2'b00;
    tick(); tick();

    // Fairness and counter saturation on the 4-requester instance.
    b_rsp_ready = 1'b1;
    b_valid = 4'hF; b_a = 16'h8F73; b_b = 16'h1C03;
    grants.delete();
    hs_done = 0;
    for (int c = 0; c < 200 && grants.size() < 16; c++) begin
      @(negedge clk);
      chk("sat_cnt", b_cnt, (hs_done > 3) ? 3 : hs_done);
      for (int i = 0; i < 4; i++) if (b_ready[i]) grants.push_back(i);
      if (b_rsp_valid && b_rsp_ready) hs_done++;
    end
    tick();
    b_valid = 4'h0;
    chk("fair_len", grants.size(), 16);
    for (int i = 0; i < grants.size(); i++) chk("fair_order", grants[i], i % 4);
    tick(); tick(); tick(); tick();
    chk("sat_final", b_cnt, 3);

    // Randomized traffic on both instances.
    for (int c = 0; c < 400; c++) begin
      a_valid = 2'($urandom); a_a = 8'($urandom); a_b = 8'($urandom);
      a_rsp_ready = ($urandom_range(0, 3) != 0);
      b_valid = 4'($urandom); b_a = 16'($urandom); b_b = 16'($urandom);
      b_rsp_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    a_valid = '0; b_valid = '0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
